multi_cycle_control_unit: RTL
=============================

# multi_cycle_control_unit

Moore-style sequencing FSM for the multi-cycle RV32I core. It walks each instruction through fetch, decode, execute, memory and writeback. At each step it drives the datapath enables and the ALU operand selects, and it issues the 2-bit `alu_op` class that `alu_control_unit` refines with funct3/funct7. It sits between the instruction register and the shared single-ALU, single-memory datapath. It also owns halt detection and the per-instruction retire pulse.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0], stable from the cycle after fetch completes.
- `mem_ready` in 1: memory handshake; the access completes in the cycle this is high.
- `alu_bcond` in 1: branch-compare result from the ALU, valid in EX_BR.
- `halt_cond` in 1: register x17 == 10, evaluated by the datapath.
- `pc_write` out 1: PC <= ALU result at the next edge.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: IR <= memory data, and MDR capture.
- `mem_to_reg` out 1: RF write data select. 0 = ALUOut, 1 = MDR.
- `reg_write` out 1: RF write enable.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = rs1.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = constant 4, 10 = imm. 11 is never driven.
- `alu_op` out 2: 00 = add, 01 = branch compare (funct3), 10 = funct-decoded (R/I).
- `retire` out 1: one-cycle pulse when an instruction completes.
- `is_halted` out 1: sticky; high in HALT.
- `state` out 4: current state encoding, for debug.

## Operation
- State encoding:
  - IF=0, ID=1, EX_ALU=2, EX_ADDR=3, MEM_RD=4, MEM_WR=5, WB_ALU=6, WB_MEM=7.
  - EX_BR=8, BR_TAKEN=9, PC_INC=10, JUMP=11, HALT=12.
  - Values 13–15 go to IF at the next edge.
- Outputs not listed for a state are 0. The datapath latches ALUOut, A and B every cycle.
- IF: `mem_read`=1, `i_or_d`=0, `ir_write`=`mem_ready`. Stay in IF while `mem_ready`=0, otherwise go to ID.
- ID: A=PC, B=4, op=00, so ALUOut <= PC+4. Next state by `opcode`:
  - 0110011 or 0010011 → EX_ALU.
  - 0000011 or 0100011 → EX_ADDR.
  - 1100011 → EX_BR.
  - 1101111 or 1100111 → JUMP.
  - 1110011 → HALT if `halt_cond`=1, else PC_INC.
  - Any other opcode → PC_INC (executes as a nop).
- EX_ALU: A=rs1, B=00 for R-type or 10 for I-type, op=10. Next: WB_ALU.
- WB_ALU: `reg_write`=1, `mem_to_reg`=0. A=PC, B=4, op=00, `pc_write`=1, `retire`=1. Next: IF.
- EX_ADDR: A=rs1, B=imm, op=00. Next: MEM_RD for a load, MEM_WR for a store.
- MEM_RD: `mem_read`=1, `i_or_d`=1, `ir_write`=0. Wait for `mem_ready`, then go to WB_MEM.
- WB_MEM: `reg_write`=1, `mem_to_reg`=1, PC <= PC+4 as in WB_ALU, `retire`=1. Next: IF.
- MEM_WR: `mem_write`=1, `i_or_d`=1.
  - In the `mem_ready` cycle: also A=PC, B=4, `pc_write`=1, `retire`=1, then go to IF.
  - Otherwise hold with `pc_write`=0.
- EX_BR: A=rs1, B=rs2, op=01. Next: BR_TAKEN if `alu_bcond`, else PC_INC.
- BR_TAKEN: A=PC, B=imm, op=00, `pc_write`=1, `retire`=1. Next: IF.
- PC_INC: A=PC, B=4, op=00, `pc_write`=1, `retire`=1. Next: IF.
- JUMP: `reg_write`=1, `mem_to_reg`=0 (writes ALUOut = PC+4). A=PC for JAL or rs1 for JALR, B=imm, op=00, `pc_write`=1, `retire`=1. Next: IF. The datapath clears bit 0 of the JALR target.
- HALT: `is_halted`=1, `retire`=1 in the first HALT cycle only, all other outputs 0. Absorbing until reset.

## Timing
- While `reset_n`=0, `state`=IF and every output is 0. This overrides the IF decode.
- Assertion of `reset_n` is asynchronous and may land in any state, including mid memory wait. State goes to IF immediately. Memory requests drop in the same cycle, and no partial `pc_write`/`reg_write` follows.
- Release is synchronous. The first cycle after release is IF with `mem_read`=1.
- Cycle counts, with `mem_ready` high on first request:
  - R/I: 4.
  - Load: 5.
  - Store: 4.
  - Branch (taken or not): 4.
  - JAL/JALR: 3.
  - Non-halting ECALL: 3.
  - Each extra `mem_ready`-low cycle in IF, MEM_RD or MEM_WR adds exactly 1 cycle.
- `retire` goes high exactly once per instruction, in the same cycle as the final `pc_write` (or first HALT cycle).
- `mem_read` and `mem_write` are never high together.
- `pc_write`=1 implies `retire`=1.
- `opcode` is sampled only in ID, EX_ADDR and JUMP. A change in other states is ignored.

## Test plan
- `reset_n` low, then release, with `mem_ready`=1 and opcode 0110011. Expect states 0,1,2,6,0. `reg_write`=1 only in WB_ALU, with A=0, B=01, `pc_write`=1 and `retire`=1 there.
- Load with `mem_ready` low for 2 cycles in MEM_RD. Expect 0,1,3,4,4,4,7 (7 cycles). WB_MEM has `mem_to_reg`=1 and `reg_write`=1. `mem_read` and `i_or_d` stay 1 throughout MEM_RD.
- Branch with `alu_bcond`=1, then `alu_bcond`=0. Expect 8→9 with B=10, and 8→10 with B=01. Each ends with `pc_write`=1 and a single `retire` pulse.
- JALR (1100111). Expect 0,1,11,0. JUMP has `reg_write`=1, `mem_to_reg`=0, A=1, B=10 and `pc_write`=1.
- ECALL with `halt_cond`=0 takes PC_INC, 3 cycles. With `halt_cond`=1 it enters HALT: `is_halted`=1, a single `retire` pulse, and it holds for 20 cycles with `pc_write`=0.
- Store with `mem_ready` low. Pull `reset_n` low mid MEM_WR. Expect `state`=0 and `mem_write`=0 the same cycle, no `pc_write`, and a fresh fetch after release.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Moore-style sequencing FSM for the multi-cycle RV32I core. Each
// instruction passes through fetch, decode, execute, memory and writeback.
// In every step the FSM drives the datapath enables, the ALU operand
// selects and the 2-bit ALU class. It also detects halt and pulses retire
// once per completed instruction.
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : asynchronous active-low reset
//   opcode     : IR[6:0]
//   mem_ready  : memory handshake, access completes in the cycle it is high
//   alu_bcond  : branch-compare result from the ALU (valid in EX_BR)
//   halt_cond  : x17 == 10, from the datapath
//   pc_write   : PC <= ALU result at the next edge
//   i_or_d     : memory address select (0 = PC, 1 = ALUOut)
//   mem_read   : memory read request
//   mem_write  : memory write request
//   ir_write   : IR / MDR capture of memory data
//   mem_to_reg : RF write data select (0 = ALUOut, 1 = MDR)
//   reg_write  : RF write enable
//   alu_src_a  : ALU A select (0 = PC, 1 = rs1)
//   alu_src_b  : ALU B select (00 = rs2, 01 = 4, 10 = imm)
//   alu_op     : 00 = add, 01 = branch compare, 10 = funct-decoded
//   retire     : one-cycle pulse per completed instruction
//   is_halted  : high while in HALT
//   state      : current state encoding, for debug
// ---------------------------------------------------------------------------
module multi_cycle_control_unit (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_bcond,
    input  logic       halt_cond,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       is_halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_ALU   = 4'd2,
        S_EX_ADDR  = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_WB_ALU   = 4'd6,
        S_WB_MEM   = 4'd7,
        S_EX_BR    = 4'd8,
        S_BR_TAKEN = 4'd9,
        S_PC_INC   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t r_state;
    state_t w_nextState;
    logic   r_isIType;
    logic   r_haltSeen;

    // State register, plus two pieces of history: whether the instruction
    // in flight is I-type (captured in ID so EX_ALU does not depend on
    // opcode), and whether HALT has already been entered (so retire
    // pulses only in the first HALT cycle).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IF;
            r_isIType  <= 1'b0;
            r_haltSeen <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == S_ID) begin
                r_isIType <= (opcode == OP_I);
            end
            if (r_state == S_HALT) begin
                r_haltSeen <= 1'b1;
            end
        end
    end

    // Next-state logic. Unused encodings fall back to IF through default.
    always_comb begin
        w_nextState = S_IF;
        case (r_state)
            S_IF:       w_nextState = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_R, OP_I:         w_nextState = S_EX_ALU;
                    OP_LOAD, OP_STORE:  w_nextState = S_EX_ADDR;
                    OP_BRANCH:          w_nextState = S_EX_BR;
                    OP_JAL, OP_JALR:    w_nextState = S_JUMP;
                    OP_SYSTEM:          w_nextState = halt_cond ? S_HALT : S_PC_INC;
                    default:            w_nextState = S_PC_INC;
                endcase
            end
            S_EX_ALU:   w_nextState = S_WB_ALU;
            S_EX_ADDR:  w_nextState = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   w_nextState = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_nextState = mem_ready ? S_IF : S_MEM_WR;
            S_WB_ALU:   w_nextState = S_IF;
            S_WB_MEM:   w_nextState = S_IF;
            S_EX_BR:    w_nextState = alu_bcond ? S_BR_TAKEN : S_PC_INC;
            S_BR_TAKEN: w_nextState = S_IF;
            S_PC_INC:   w_nextState = S_IF;
            S_JUMP:     w_nextState = S_IF;
            S_HALT:     w_nextState = S_HALT;
            default:    w_nextState = S_IF;
        endcase
    end

    // Output decode. Every step that finishes an instruction raises
    // pc_write and retire together. Holding reset_n low forces every
    // output to zero, which also cancels any memory request in flight.
    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        is_halted  = 1'b0;
        case (r_state)
            S_IF: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_ID: begin
                alu_src_b = 2'b01;
            end
            S_EX_ALU: begin
                alu_src_a = 1'b1;
                alu_src_b = r_isIType ? 2'b10 : 2'b00;
                alu_op    = 2'b10;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            S_EX_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src_b  = 2'b01;
                pc_write   = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
            end
            S_EX_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
            end
            S_BR_TAKEN: begin
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            S_PC_INC: begin
                alu_src_b = 2'b01;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                reg_write = 1'b1;
                alu_src_a = (opcode == OP_JALR);
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            S_HALT: begin
                is_halted = 1'b1;
                retire    = ~r_haltSeen;
            end
            default: begin
            end
        endcase
        if (!reset_n) begin
            pc_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            retire     = 1'b0;
            is_halted  = 1'b0;
        end
    end

    assign state = r_state;

endmodule
